// File: rtl/states_pkg.sv
// Shared lamp codes, controller state codes and monitor types for the
// traffic light controller and its conflict monitor.
package states;

  localparam logic [1:0] G   = 2'b00;
  localparam logic [1:0] Y   = 2'b01;
  localparam logic [1:0] R   = 2'b10;
  localparam logic [1:0] BAD = 2'b11;

  localparam logic [1:0] GR = 2'd0;
  localparam logic [1:0] YR = 2'd1;
  localparam logic [1:0] RG = 2'd2;
  localparam logic [1:0] RY = 2'd3;

  typedef enum logic [1:0] {INIT, RUN, FAULT} mon_state_t;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_ILLEGAL  = 3'd2;
  localparam logic [2:0] FC_BAD_TR   = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;
  localparam logic [2:0] FC_LONG_Y   = 3'd5;

  localparam logic [2:0] LAMP_RED = 3'b100;

  // Holding a code, or stepping G->Y, Y->R, R->G, is the only legal per-head motion.
  function automatic logic legal_step(input logic [1:0] prv, input logic [1:0] cur);
    return (prv == cur) || (prv == G && cur == Y) ||
           (prv == Y && cur == R) || (prv == R && cur == G);
  endfunction

endpackage

// File: rtl/light_decode.sv
// Lamp code to one-hot {red,yellow,green}; the illegal code shows red.
module light_decode
  import states::*;
(
  input  logic [1:0] code,
  output logic [2:0] lamps
);

  always_comb begin
    lamps = LAMP_RED;
    case (code)
      G:       lamps = 3'b001;
      Y:       lamps = 3'b010;
      R:       lamps = 3'b100;
      default: lamps = LAMP_RED;
    endcase
  end

endmodule

// File: rtl/light_conflict_monitor.sv
// Decodes controller lamp codes to lamp drives and latches a flashing-red
// fault on conflicts, illegal codes, illegal steps and bad yellow durations.
module light_conflict_monitor
  import states::*;
#(
  parameter int unsigned MIN_YELLOW = 10,
  parameter int unsigned MAX_YELLOW = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] ml,
  input  logic [1:0] sl,
  input  logic       clr_fault,
  output logic [2:0] main_lamps,
  output logic [2:0] side_lamps,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [5:0] MIN_Y = 6'(MIN_YELLOW);
  localparam logic [5:0] MAX_Y = 6'(MAX_YELLOW);

  mon_state_t state;
  logic [1:0] cur_m, cur_s, prv_m, prv_s;
  logic [4:0] ycnt;
  logic       flash, gr_seen;

  logic [2:0] dec_m, dec_s;
  logic       any_y, cur_gr, flash_nxt, cause_present;
  logic       conflict, illegal, bad_tr, short_y, long_y;
  logic [2:0] viol_code;

  light_decode u_dec_main (.code(cur_m), .lamps(dec_m));
  light_decode u_dec_side (.code(cur_s), .lamps(dec_s));

  always_comb begin
    any_y     = (cur_m == Y) || (cur_s == Y);
    cur_gr    = (cur_m == G) && (cur_s == R);
    flash_nxt = tick ? ~flash : flash;
    conflict  = (cur_m != R) && (cur_s != R);
    illegal   = (cur_m == BAD) || (cur_s == BAD);
    bad_tr    = !legal_step(prv_m, cur_m) || !legal_step(prv_s, cur_s);
    // Duration checks see ycnt before this cycle's tick increment.
    short_y   = (((prv_m == Y) && (cur_m != Y)) || ((prv_s == Y) && (cur_s != Y))) &&
                ({1'b0, ycnt} < MIN_Y);
    long_y    = any_y && ({1'b0, ycnt} > MAX_Y);

    viol_code = FC_NONE;
    if      (conflict) viol_code = FC_CONFLICT;
    else if (illegal)  viol_code = FC_ILLEGAL;
    else if (bad_tr)   viol_code = FC_BAD_TR;
    else if (short_y)  viol_code = FC_SHORT_Y;
    else if (long_y)   viol_code = FC_LONG_Y;

    cause_present = 1'b0;
    case (fault_code)
      FC_CONFLICT: cause_present = conflict;
      FC_ILLEGAL:  cause_present = illegal;
      FC_BAD_TR:   cause_present = bad_tr;
      FC_SHORT_Y:  cause_present = short_y;
      FC_LONG_Y:   cause_present = long_y;
      default:     cause_present = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      cur_m      <= R;
      cur_s      <= R;
      prv_m      <= R;
      prv_s      <= R;
      ycnt       <= '0;
      flash      <= 1'b1;
      gr_seen    <= 1'b0;
      main_lamps <= LAMP_RED;
      side_lamps <= LAMP_RED;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      prv_m <= cur_m;
      prv_s <= cur_s;
      cur_m <= ml;
      cur_s <= sl;

      if (!any_y)
        ycnt <= '0;
      else if (tick && (ycnt != '1))
        ycnt <= ycnt + 5'd1;

      case (state)
        INIT: begin
          main_lamps <= LAMP_RED;
          side_lamps <= LAMP_RED;
          flash      <= 1'b1;
          gr_seen    <= cur_gr;
          if (cur_gr && gr_seen) begin
            state      <= RUN;
            main_lamps <= dec_m;
            side_lamps <= dec_s;
          end
        end
        RUN: begin
          gr_seen <= 1'b0;
          flash   <= 1'b1;
          // A detected violation is never shown: red is forced on the detecting edge.
          if (viol_code != FC_NONE) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= viol_code;
            main_lamps <= LAMP_RED;
            side_lamps <= LAMP_RED;
          end else begin
            main_lamps <= dec_m;
            side_lamps <= dec_s;
          end
        end
        FAULT: begin
          gr_seen <= 1'b0;
          if (clr_fault && !cause_present) begin
            state      <= INIT;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            flash      <= 1'b1;
            main_lamps <= LAMP_RED;
            side_lamps <= LAMP_RED;
          end else begin
            flash      <= flash_nxt;
            main_lamps <= {flash_nxt, 2'b00};
            side_lamps <= {flash_nxt, 2'b00};
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor with a queue of expected outputs.
module tb_light_conflict_monitor;
  import states::*;

  logic       clk = 1'b0;
  logic       rst, tick, clr_fault;
  logic [1:0] ml, sl;
  logic [2:0] main_lamps, side_lamps, fault_code;
  logic       fault;

  int unsigned checks = 0;
  int unsigned passed = 0;

  typedef struct {
    string      tag;
    logic [2:0] m;
    logic [2:0] s;
    logic       f;
    logic [2:0] fc;
  } exp_t;
  exp_t exp_q[$];

  light_conflict_monitor #(.MIN_YELLOW(10), .MAX_YELLOW(12)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ml(ml), .sl(sl), .clr_fault(clr_fault),
    .main_lamps(main_lamps), .side_lamps(side_lamps),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    clk_n(1);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      clk_n(1);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] m, input logic [2:0] s,
                            input logic f, input logic [2:0] fc);
    exp_q.push_back('{tag, m, s, f, fc});
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL scoreboard_empty got 0 entries need 1");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (main_lamps === e.m) passed++;
    else $error("FAIL %s main_lamps got %b need %b", e.tag, main_lamps, e.m);
    checks++;
    assert (side_lamps === e.s) passed++;
    else $error("FAIL %s side_lamps got %b need %b", e.tag, side_lamps, e.s);
    checks++;
    assert (fault === e.f) passed++;
    else $error("FAIL %s fault got %b need %b", e.tag, fault, e.f);
    checks++;
    assert (fault_code === e.fc) passed++;
    else $error("FAIL %s fault_code got %0d need %0d", e.tag, fault_code, e.fc);
  endtask

  task automatic check_ycnt(input string tag, input logic [4:0] need);
    checks++;
    assert (dut.ycnt === need) passed++;
    else $error("FAIL %s ycnt got %0d need %0d", tag, dut.ycnt, need);
  endtask

  task automatic clear_to_run(input string tag);
    ml = G; sl = R;
    clk_n(1);
    clr_fault = 1'b1;
    expect_out({tag, "_init"}, 3'b100, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    clr_fault = 1'b0;
    expect_out({tag, "_run"}, 3'b001, 3'b100, 1'b0, FC_NONE);
    clk_n(2);
    check_out();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; clr_fault = 1'b0; ml = R; sl = R;
    #3;
    expect_out("reset", 3'b100, 3'b100, 1'b0, FC_NONE);
    check_out();
    check_ycnt("reset_ycnt", 5'd0);
    clk_n(2);
    rst = 1'b0;

    // INIT -> RUN with (G,R)
    ml = G; sl = R;
    expect_out("init_wait", 3'b100, 3'b100, 1'b0, FC_NONE);
    clk_n(2);
    check_out();
    expect_out("init_run", 3'b001, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();

    // Full legal cycle with 2-clock lamp latency
    ml = Y; sl = R;
    expect_out("yr_lat1", 3'b001, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    expect_out("yr_lat2", 3'b010, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    ticks(10);
    ml = R; sl = G;
    expect_out("rg", 3'b100, 3'b001, 1'b0, FC_NONE);
    clk_n(2);
    check_out();
    ml = R; sl = Y;
    clk_n(2);
    ticks(10);
    ml = G; sl = R;
    expect_out("gr_again", 3'b001, 3'b100, 1'b0, FC_NONE);
    clk_n(2);
    check_out();

    // Conflict (G,G), then flashing red
    ml = G; sl = G;
    expect_out("conf_lat1", 3'b001, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    expect_out("conflict", 3'b100, 3'b100, 1'b1, FC_CONFLICT);
    clk_n(1);
    check_out();
    expect_out("flash_off", 3'b000, 3'b000, 1'b1, FC_CONFLICT);
    pulse_tick();
    check_out();
    expect_out("flash_on", 3'b100, 3'b100, 1'b1, FC_CONFLICT);
    pulse_tick();
    check_out();
    clr_fault = 1'b1;
    expect_out("clr_blocked", 3'b100, 3'b100, 1'b1, FC_CONFLICT);
    clk_n(1);
    check_out();
    clr_fault = 1'b0;
    ml = G; sl = R;
    clk_n(1);
    clr_fault = 1'b1;
    expect_out("clr_init", 3'b100, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    expect_out("clr_held_init", 3'b100, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    expect_out("clr_held_run", 3'b001, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    clr_fault = 1'b0;

    // Short yellow: 9 ticks then leave Y
    ml = Y; sl = R;
    clk_n(2);
    ticks(9);
    ml = R; sl = G;
    expect_out("short_lat1", 3'b010, 3'b100, 1'b0, FC_NONE);
    clk_n(1);
    check_out();
    expect_out("short_y", 3'b100, 3'b100, 1'b1, FC_SHORT_Y);
    clk_n(1);
    check_out();
    clear_to_run("after_short");

    // Long yellow: 12 ticks legal, 13th faults
    ml = Y; sl = R;
    clk_n(2);
    ticks(12);
    expect_out("yellow_12", 3'b010, 3'b100, 1'b0, FC_NONE);
    clk_n(2);
    check_out();
    check_ycnt("ycnt_12", 5'd12);
    expect_out("yellow_13", 3'b010, 3'b100, 1'b0, FC_NONE);
    pulse_tick();
    check_out();
    expect_out("long_y", 3'b100, 3'b100, 1'b1, FC_LONG_Y);
    clk_n(1);
    check_out();
    clear_to_run("after_long");

    // Bad transition: main G -> R
    ml = R; sl = R;
    expect_out("bad_tr", 3'b100, 3'b100, 1'b1, FC_BAD_TR);
    clk_n(2);
    check_out();
    clear_to_run("after_bad");

    // Illegal code plus conflict: lowest code wins
    ml = BAD; sl = G;
    expect_out("ill_conf", 3'b100, 3'b100, 1'b1, FC_CONFLICT);
    clk_n(2);
    check_out();
    clear_to_run("after_ill");

    // Illegal code alone
    ml = BAD; sl = R;
    expect_out("illegal", 3'b100, 3'b100, 1'b1, FC_ILLEGAL);
    clk_n(2);
    check_out();
    clear_to_run("after_illegal");

    // Asynchronous reset mid-yellow
    ml = Y; sl = R;
    clk_n(2);
    ticks(3);
    check_ycnt("ycnt_3", 5'd3);
    #2 rst = 1'b1;
    #1;
    expect_out("rst_yellow", 3'b100, 3'b100, 1'b0, FC_NONE);
    check_out();
    check_ycnt("rst_ycnt", 5'd0);
    clk_n(1);
    rst = 1'b0;

    // Asynchronous reset while in FAULT
    ml = G; sl = R;
    clk_n(3);
    ml = G; sl = G;
    expect_out("pre_rst_fault", 3'b100, 3'b100, 1'b1, FC_CONFLICT);
    clk_n(2);
    check_out();
    #2 rst = 1'b1;
    #1;
    expect_out("rst_fault", 3'b100, 3'b100, 1'b0, FC_NONE);
    check_out();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
# light_conflict_monitor

Receiving end of the traffic light controller's `ml`/`sl` lamp-code outputs. The block decodes the 2-bit codes for the main and side signal heads into one-hot lamp drives. It also checks the code stream for safety violations: green/yellow conflict, illegal code, illegal sequence, and yellow duration. On any violation it latches a fault and forces both heads to flashing red until the fault is cleared. It sits between the controller and the lamp driver pins.

## Interface
Parameters:
- `MIN_YELLOW`, 10: minimum legal yellow duration, in `tick` pulses.
- `MAX_YELLOW`, 12: maximum legal yellow duration, in `tick` pulses.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle 1 Hz strobe, synchronous to `clk`.
- `ml`  in  2  main head lamp code from the controller.
- `sl`  in  2  side head lamp code from the controller.
- `clr_fault`  in  1  level; requests exit from FAULT.
- `main_lamps`  out  3  `{red,yellow,green}` one-hot drive for the main head.
- `side_lamps`  out  3  `{red,yellow,green}` one-hot drive for the side head.
- `fault`  out  1  high while in FAULT.
- `fault_code`  out  3  latched cause of the fault; 0 when no fault.

Decided: one clock; reset is asynchronous and active-high.

## Operation
- Lamp code encoding (from the `states` package): G=2'b00, Y=2'b01, R=2'b10. 2'b11 is illegal.
- The inputs are registered into `cur_m`/`cur_s` every clock. The previous registered values are kept in `prv_m`/`prv_s`.
- FSM states: INIT, RUN, FAULT.
  - INIT: both heads drive red steady. Move to RUN once `cur` = (G,R) for 2 consecutive clocks.
  - RUN: lamps follow the decoded `cur` codes. The checks below run every clock.
  - FAULT: `fault`=1. Both heads drive `{flash,0,0}`; `flash` toggles on each `tick`. Move to INIT when `clr_fault`=1 and the cause is no longer present.
- Checks in RUN; the fault code is shown per check:
  - 1, conflict: neither head is R.
  - 2, illegal code: either code is 2'b11.
  - 3, bad transition: a per-head change other than G→Y, Y→R, R→G.
  - 4, short yellow: a head leaves Y with `ycnt` < `MIN_YELLOW`.
  - 5, long yellow: `ycnt` reaches `MAX_YELLOW`+1 while a head is Y.
- Multiple simultaneous causes: the lowest code number is latched.
- On detection, the next state is FAULT. Lamps are forced red from that same edge; a violating lamp pattern is never driven.
- `ycnt` is a 5-bit yellow timer:
  - Clears on any clock where neither head is Y.
  - Increments on `tick` while either head is Y, and saturates at 31.
  - Is not cleared by a Y→Y hold.
- Yellow-duration checks use the `ycnt` value before that cycle's increment.
- `fault_code` holds its value through FAULT and clears to 0 when FAULT is exited.
- `clr_fault` held high outside FAULT has no effect.

## Timing
- Reset values: state=INIT, `main_lamps`=3'b100, `side_lamps`=3'b100, `fault`=0, `fault_code`=0, `ycnt`=0, `flash`=1, `cur`/`prv`=R.
- Latency from `ml`/`sl` change to lamp change: 2 clocks (input register plus output register).
- Latency from violating input to `fault`=1 and forced red: 2 clocks.
- INIT→RUN takes 2 clocks of stable (G,R) after they are registered. The first RUN clock then drives G on main and R on side.
- A FAULT→INIT exit takes 1 clock after `clr_fault` is sampled high. A further ≥2 clocks of (G,R) are then required before RUN.
- Asserting `rst` mid-operation, including in FAULT, returns all outputs to reset values immediately, without waiting for a clock.
- `tick` and a transition out of Y in the same clock: the short-yellow compare uses the pre-increment `ycnt`.

## Structure
- `states` package: the light code constants (G, Y, R), the controller state constants (GR, YR, RG, RY), a new `mon_state_t` {INIT, RUN, FAULT}, and the fault code constants FC_NONE through FC_LONG_Y.
- One sub-module, `light_decode`: combinational, 2-bit code → 3-bit one-hot, with 2'b11 → 3'b100. It is instantiated twice. All remaining logic lives in the top-level module.

## Test plan
- Reset, then drive (G,R) for 3 clocks → RUN, `main_lamps`=001, `side_lamps`=100, `fault`=0.
- Full legal cycle GR→YR (hold 10 ticks)→RG→RY (hold 10 ticks)→GR → no fault. Lamps track the codes with 2-clock latency.
- From RUN at GR, drive (G,G) → `fault`=1 and `fault_code`=1 after 2 clocks. Both heads then flash red, toggling per tick.
- Hold YR for 9 ticks then switch to RG → `fault_code`=4. Separately, hold YR for 13 ticks → `fault_code`=5.
- Drive main G→R directly → `fault_code`=3. Drive `ml`=2'b11 together with a conflict → `fault_code`=1, because the lowest code wins.
- In FAULT, assert `clr_fault` with the inputs at (G,R) → INIT, then RUN after 2 clocks, `fault_code`=0. Assert `rst` mid-yellow → lamps 100/100 immediately and `ycnt`=0.
